gpu_pixel_arbiter: RTL and testbench
====================================

# gpu_pixel_arbiter

Shares the single framebuffer pixel-write port among the three drawing engines (line, fill, arc). Each cycle it picks one pending pixel request by round-robin and acknowledges it. It clips the pixel against the screen, converts (x, y) to a linear framebuffer address, and holds the pixel in a one-deep output register under a valid/ready handshake to the memory controller. It sits between the drawing engines and the framebuffer memory controller; the current draw colour comes from the command controller.

## Interface
Parameters:
- SCREEN_WIDTH, 640, visible pixels per row
- SCREEN_HEIGHT, 480, visible rows
- WIDTH_BITS, 10, x coordinate width
- HEIGHT_BITS, 9, y coordinate width
- CHANNEL_BITS, 8, bits per colour channel
- ADDR_BITS, 19, framebuffer address width (ceil log2 of SCREEN_WIDTH*SCREEN_HEIGHT)

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - clk  in  1  system clock
  - rst  in  1  synchronous active-high reset
- Line engine:
  - req_line_i  in  1  line engine has a pixel pending
  - x_line_i  in  WIDTH_BITS  line pixel x
  - y_line_i  in  HEIGHT_BITS  line pixel y
  - ack_line_o  out  1  line pixel accepted this cycle
- Fill engine: req_fill_i / x_fill_i / y_fill_i / ack_fill_o, same widths and meanings as the line engine.
- Arc engine: req_arc_i / x_arc_i / y_arc_i / ack_arc_o, same widths and meanings as the line engine.
- Colour from the command controller:
  - r_i, g_i, b_i  in  CHANNEL_BITS  current draw colour
- Memory side:
  - mem_valid_o  out  1  output register holds a pixel
  - mem_addr_o  out  ADDR_BITS  y*SCREEN_WIDTH + x
  - mem_r_o, mem_g_o, mem_b_o  out  CHANNEL_BITS  pixel colour
  - mem_ready_i  in  1  memory accepts the pixel this cycle
- Status:
  - clipped_o  out  1  one-cycle pulse: the accepted pixel was out of bounds and dropped
  - idle_o  out  1  no request pending and output register empty

## Operation
- Requester contract:
  - Asserts req_*_i and holds its coordinates stable until the matching ack_*_o is high at a clock edge.
  - May present its next pixel in the following cycle.
- Accept condition: accept = !mem_valid_o || mem_ready_i.
  - When accept is 0, every ack_*_o is 0 and the round-robin pointer holds.
- Grant and acks:
  - When accept is 1 and at least one request is pending, exactly one ack_*_o is high, combinationally in the same cycle.
  - The winner is the first pending requester after last_grant in the cyclic order line(0) → fill(1) → arc(2) → line.
  - last_grant updates to the winner at the edge.
- In-bounds capture: when the winner has x < SCREEN_WIDTH and y < SCREEN_HEIGHT, at the edge:
  - mem_valid_o ← 1
  - mem_addr_o ← y*SCREEN_WIDTH + x, computed at ADDR_BITS width with no truncation for legal coordinates
  - mem_r_o/g_o/b_o ← r_i/g_i/b_i sampled in the grant cycle
- Out-of-bounds handling: the winner is still acked, but nothing enters the output register.
  - If mem_ready_i drained the register that cycle, mem_valid_o ← 0.
  - clipped_o is 1 for the next cycle.
- Drain with no new grant: when accept is 1, no request is pending and mem_ready_i=1, then mem_valid_o ← 0.
- idle_o = !(req_line_i|req_fill_i|req_arc_i) && !mem_valid_o.

## Timing
- Reset values:
  - mem_valid_o=0, mem_addr_o=0, mem_r/g/b_o=0
  - clipped_o=0
  - last_grant=arc, so line has top priority first
  - idle_o follows its equation
- Latency:
  - Request to ack: 0 cycles when accept=1.
  - Ack to mem_valid_o: 1 cycle.
- Throughput: 1 pixel/cycle while mem_ready_i stays high.
- Fairness: with all three requests held continuously, the grant order is line, fill, arc, line, …; no requester waits more than 2 grants.
- Back-pressure: the output register holds its contents unchanged while mem_valid_o=1 and mem_ready_i=0.
- Simultaneous drain and grant: mem_ready_i=1 with a pending request loads the new pixel in the same edge; mem_valid_o stays 1 with no bubble.
- Reset mid-operation: any pixel in the output register is discarded, and pixels acked in the reset cycle are lost. Engines must be reset together with this block.

## Structure
- Shared definitions header (gpu_definitions.vh) holds:
  - screen constants: SCREEN_WIDTH, SCREEN_HEIGHT
  - bit widths: WIDTH_BITS, HEIGHT_BITS, CHANNEL_BITS, ADDR_BITS
  - requester index encoding: LINE=0, FILL=1, ARC=2
- Sub-module gpu_rr_arbiter:
  - Generic 3-way round-robin with a one-hot grant, an enable (accept) input and an internal last_grant register.
  - The top level adds the clip check, the address multiply-add and the output register.

## Test plan
- Reset, then drive req_line_i=1, x=10, y=2, colour (0xFF,0x00,0x80), mem_ready_i=1 → ack_line_o=1 in that cycle; next cycle mem_valid_o=1, mem_addr_o=1290, colour 0xFF/0x00/0x80.
- All three requests held for 6 cycles, mem_ready_i=1 → ack sequence line, fill, arc, line, fill, arc; one pixel per cycle on mem_*.
- mem_ready_i=0 for 4 cycles with a pixel in the register and line requesting → no acks; mem_addr_o stable; when ready rises, the line pixel is acked and loaded in the same cycle.
- Fill requests x=640, y=0 → ack_fill_o=1, clipped_o pulses the next cycle, mem_valid_o stays 0. Then x=639, y=479 → mem_addr_o=307199.
- Only arc requesting, after a fill grant → arc is granted immediately, with no idle cycle for line/fill.
- Assert rst while mem_valid_o=1 and requests are pending → next cycle mem_valid_o=0; the first grant after reset goes to line.

Source files
------------

// File: rtl/gpu_pixel_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpu_pixel_arbiter_pkg
// Description : Shared definitions for the pixel-write arbiter. It holds the
//               screen geometry, the field widths and the requester index
//               encoding (line = 0, fill = 1, arc = 2), plus a one-hot to
//               index helper.
// Revision    : 1.0 - initial release
// ============================================================================
package gpu_pixel_arbiter_pkg;

    localparam int SCREEN_WIDTH  = 640;
    localparam int SCREEN_HEIGHT = 480;
    localparam int WIDTH_BITS    = 10;
    localparam int HEIGHT_BITS   = 9;
    localparam int CHANNEL_BITS  = 8;
    localparam int ADDR_BITS     = 19;

    typedef enum logic [1:0] {
        REQ_LINE = 2'd0,
        REQ_FILL = 2'd1,
        REQ_ARC  = 2'd2
    } req_idx_e;

    // Converts a one-hot grant vector into its requester index.
    function automatic req_idx_e onehot_to_idx(input logic [2:0] oh);
        req_idx_e idx;
        idx = REQ_LINE;
        if (oh[REQ_FILL]) begin
            idx = REQ_FILL;
        end else if (oh[REQ_ARC]) begin
            idx = REQ_ARC;
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gpu_pixel_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : gpu_pixel_arbiter_rr
// Description : Three-way round-robin arbiter with one-hot grant. The grant is
//               combinational and only issued while en_i is high; the most
//               recent winner is remembered and gets lowest priority next.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               en_i          - grants allowed this cycle
//               req_i[2:0]    - pending requests (index = requester id)
//               gnt_o[2:0]    - one-hot grant, zero when disabled / idle
// Revision    : 1.0 - initial release
// ============================================================================
module gpu_pixel_arbiter_rr
    import gpu_pixel_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic [2:0] req_i,
    output logic [2:0] gnt_o
);

    req_idx_e   last_grant_q;
    req_idx_e   last_grant_d;
    logic [2:0] w_gnt;

    // Search starts at the requester just after the previous winner.
    always_comb begin
        w_gnt = 3'b000;
        if (en_i) begin
            case (last_grant_q)
                REQ_LINE: begin
                    if      (req_i[REQ_FILL]) w_gnt = 3'b010;
                    else if (req_i[REQ_ARC])  w_gnt = 3'b100;
                    else if (req_i[REQ_LINE]) w_gnt = 3'b001;
                end
                REQ_FILL: begin
                    if      (req_i[REQ_ARC])  w_gnt = 3'b100;
                    else if (req_i[REQ_LINE]) w_gnt = 3'b001;
                    else if (req_i[REQ_FILL]) w_gnt = 3'b010;
                end
                default: begin
                    if      (req_i[REQ_LINE]) w_gnt = 3'b001;
                    else if (req_i[REQ_FILL]) w_gnt = 3'b010;
                    else if (req_i[REQ_ARC])  w_gnt = 3'b100;
                end
            endcase
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (|w_gnt) begin
            last_grant_d = onehot_to_idx(w_gnt);
        end
    end

    // Reset to arc so that line is first in line after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= REQ_ARC;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    assign gnt_o = w_gnt;

endmodule
`default_nettype wire

// File: rtl/gpu_pixel_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : gpu_pixel_arbiter
// Description : Shares the framebuffer pixel-write port among the line, fill
//               and arc engines. One request is acked per accepting cycle by
//               round-robin; the pixel is clipped to the screen, turned into a
//               linear address and held in a one-deep valid/ready register.
// Ports       : clk, rst                        - clock, sync active-high reset
//               req_/x_/y_{line,fill,arc}_i     - engine pixel requests
//               ack_{line,fill,arc}_o           - same-cycle request accept
//               r_i, g_i, b_i                   - current draw colour
//               mem_valid_o, mem_addr_o,
//               mem_{r,g,b}_o, mem_ready_i      - framebuffer write handshake
//               clipped_o                       - accepted pixel was dropped
//               idle_o                          - nothing pending or held
// Revision    : 1.0 - initial release
// ============================================================================
module gpu_pixel_arbiter
    import gpu_pixel_arbiter_pkg::*;
#(
    parameter int SCREEN_WIDTH  = gpu_pixel_arbiter_pkg::SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT = gpu_pixel_arbiter_pkg::SCREEN_HEIGHT,
    parameter int WIDTH_BITS    = gpu_pixel_arbiter_pkg::WIDTH_BITS,
    parameter int HEIGHT_BITS   = gpu_pixel_arbiter_pkg::HEIGHT_BITS,
    parameter int CHANNEL_BITS  = gpu_pixel_arbiter_pkg::CHANNEL_BITS,
    parameter int ADDR_BITS     = gpu_pixel_arbiter_pkg::ADDR_BITS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_line_i,
    input  logic [WIDTH_BITS-1:0]   x_line_i,
    input  logic [HEIGHT_BITS-1:0]  y_line_i,
    output logic                    ack_line_o,
    input  logic                    req_fill_i,
    input  logic [WIDTH_BITS-1:0]   x_fill_i,
    input  logic [HEIGHT_BITS-1:0]  y_fill_i,
    output logic                    ack_fill_o,
    input  logic                    req_arc_i,
    input  logic [WIDTH_BITS-1:0]   x_arc_i,
    input  logic [HEIGHT_BITS-1:0]  y_arc_i,
    output logic                    ack_arc_o,
    input  logic [CHANNEL_BITS-1:0] r_i,
    input  logic [CHANNEL_BITS-1:0] g_i,
    input  logic [CHANNEL_BITS-1:0] b_i,
    output logic                    mem_valid_o,
    output logic [ADDR_BITS-1:0]    mem_addr_o,
    output logic [CHANNEL_BITS-1:0] mem_r_o,
    output logic [CHANNEL_BITS-1:0] mem_g_o,
    output logic [CHANNEL_BITS-1:0] mem_b_o,
    input  logic                    mem_ready_i,
    output logic                    clipped_o,
    output logic                    idle_o
);

    // One extra bit so the limits fit even when they equal 2**BITS.
    localparam logic [WIDTH_BITS:0]  c_x_limit = (WIDTH_BITS+1)'(SCREEN_WIDTH);
    localparam logic [HEIGHT_BITS:0] c_y_limit = (HEIGHT_BITS+1)'(SCREEN_HEIGHT);
    localparam logic [ADDR_BITS-1:0] c_row_pitch = ADDR_BITS'(SCREEN_WIDTH);

    logic [2:0]             w_req;
    logic [2:0]             w_gnt;
    logic                   w_accept;
    logic [WIDTH_BITS-1:0]  w_x;
    logic [HEIGHT_BITS-1:0] w_y;
    logic                   w_in_bounds;
    logic [ADDR_BITS-1:0]   w_addr;

    logic                    valid_q;
    logic [ADDR_BITS-1:0]    addr_q;
    logic [CHANNEL_BITS-1:0] r_q, g_q, b_q;
    logic                    clipped_q;

    assign w_req    = {req_arc_i, req_fill_i, req_line_i};
    assign w_accept = !valid_q || mem_ready_i;

    gpu_pixel_arbiter_rr u_rr (
        .clk   (clk),
        .rst   (rst),
        .en_i  (w_accept),
        .req_i (w_req),
        .gnt_o (w_gnt)
    );

    always_comb begin
        w_x = x_line_i;
        w_y = y_line_i;
        if (w_gnt[REQ_FILL]) begin
            w_x = x_fill_i;
            w_y = y_fill_i;
        end else if (w_gnt[REQ_ARC]) begin
            w_x = x_arc_i;
            w_y = y_arc_i;
        end
    end

    assign w_in_bounds = ({1'b0, w_x} < c_x_limit) && ({1'b0, w_y} < c_y_limit);
    assign w_addr      = ADDR_BITS'(w_y) * c_row_pitch + ADDR_BITS'(w_x);

    // Whenever the register may change (accept), it ends up holding a pixel
    // only if an in-bounds winner is loaded; clipped winners or no winner
    // leave it empty, which also covers the drain-only case.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            addr_q    <= '0;
            r_q       <= '0;
            g_q       <= '0;
            b_q       <= '0;
            clipped_q <= 1'b0;
        end else begin
            clipped_q <= (|w_gnt) && !w_in_bounds;
            if (w_accept) begin
                valid_q <= (|w_gnt) && w_in_bounds;
                if ((|w_gnt) && w_in_bounds) begin
                    addr_q <= w_addr;
                    r_q    <= r_i;
                    g_q    <= g_i;
                    b_q    <= b_i;
                end
            end
        end
    end

    assign ack_line_o  = w_gnt[REQ_LINE];
    assign ack_fill_o  = w_gnt[REQ_FILL];
    assign ack_arc_o   = w_gnt[REQ_ARC];
    assign mem_valid_o = valid_q;
    assign mem_addr_o  = addr_q;
    assign mem_r_o     = r_q;
    assign mem_g_o     = g_q;
    assign mem_b_o     = b_q;
    assign clipped_o   = clipped_q;
    assign idle_o      = !(|w_req) && !valid_q;

endmodule
`default_nettype wire

// File: tb/tb_gpu_pixel_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpu_pixel_arbiter
// Description : Directed self-checking bench for gpu_pixel_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpu_pixel_arbiter;

    logic        clk;
    logic        rst;
    logic        req_line, req_fill, req_arc;
    logic [9:0]  x_line, x_fill, x_arc;
    logic [8:0]  y_line, y_fill, y_arc;
    logic        ack_line, ack_fill, ack_arc;
    logic [7:0]  r, g, b;
    logic        mem_valid;
    logic [18:0] mem_addr;
    logic [7:0]  mem_r, mem_g, mem_b;
    logic        mem_ready;
    logic        clipped;
    logic        idle;

    int vectors;
    int miscompares;

    gpu_pixel_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req_line_i  (req_line),
        .x_line_i    (x_line),
        .y_line_i    (y_line),
        .ack_line_o  (ack_line),
        .req_fill_i  (req_fill),
        .x_fill_i    (x_fill),
        .y_fill_i    (y_fill),
        .ack_fill_o  (ack_fill),
        .req_arc_i   (req_arc),
        .x_arc_i     (x_arc),
        .y_arc_i     (y_arc),
        .ack_arc_o   (ack_arc),
        .r_i         (r),
        .g_i         (g),
        .b_i         (b),
        .mem_valid_o (mem_valid),
        .mem_addr_o  (mem_addr),
        .mem_r_o     (mem_r),
        .mem_g_o     (mem_g),
        .mem_b_o     (mem_b),
        .mem_ready_i (mem_ready),
        .clipped_o   (clipped),
        .idle_o      (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Check the one-hot ack pattern {arc, fill, line} after inputs settle.
    task automatic chk_acks(input string tag, input logic [2:0] exp);
        #1;
        chk(tag, {29'd0, ack_arc, ack_fill, ack_line}, {29'd0, exp});
    endtask

    logic [2:0]  seq_ack  [6];
    logic [18:0] seq_addr [6];

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1;
        req_line = 0; req_fill = 0; req_arc = 0;
        x_line = 0; y_line = 0; x_fill = 0; y_fill = 0; x_arc = 0; y_arc = 0;
        r = 0; g = 0; b = 0;
        mem_ready = 0;

        tick;
        tick;
        rst = 1'b0;
        #1;
        chk("rst_valid",   32'(mem_valid), 32'd0);
        chk("rst_addr",    32'(mem_addr),  32'd0);
        chk("rst_rgb",     {8'd0, mem_r, mem_g, mem_b}, 32'd0);
        chk("rst_clipped", 32'(clipped),   32'd0);
        chk("rst_idle",    32'(idle),      32'd1);

        // Single line pixel: (10,2) -> 2*640+10 = 1290.
        req_line = 1; x_line = 10; y_line = 2;
        r = 8'hFF; g = 8'h00; b = 8'h80; mem_ready = 1;
        chk_acks("t1_ack", 3'b001);
        chk("t1_idle_busy", 32'(idle), 32'd0);
        tick;
        chk("t1_valid", 32'(mem_valid), 32'd1);
        chk("t1_addr",  32'(mem_addr),  32'd1290);
        chk("t1_rgb",   {8'd0, mem_r, mem_g, mem_b}, 32'h00FF0080);
        req_line = 0;

        // All three held; last winner was line, so fill, arc, line, ...
        req_line = 1; x_line = 1; y_line = 0;
        req_fill = 1; x_fill = 2; y_fill = 0;
        req_arc  = 1; x_arc  = 3; y_arc  = 1;
        r = 8'h11; g = 8'h22; b = 8'h33;
        seq_ack[0] = 3'b010; seq_addr[0] = 19'd2;
        seq_ack[1] = 3'b100; seq_addr[1] = 19'd643;
        seq_ack[2] = 3'b001; seq_addr[2] = 19'd1;
        seq_ack[3] = 3'b010; seq_addr[3] = 19'd2;
        seq_ack[4] = 3'b100; seq_addr[4] = 19'd643;
        seq_ack[5] = 3'b001; seq_addr[5] = 19'd1;
        for (int i = 0; i < 6; i++) begin
            chk_acks($sformatf("rr_ack%0d", i), seq_ack[i]);
            tick;
            chk($sformatf("rr_valid%0d", i), 32'(mem_valid), 32'd1);
            chk($sformatf("rr_addr%0d", i),  32'(mem_addr),  32'(seq_addr[i]));
        end
        chk("rr_rgb", {8'd0, mem_r, mem_g, mem_b}, 32'h00112233);
        req_fill = 0; req_arc = 0;

        // Back-pressure: register holds addr 1, line waits with (5,3) = 1925.
        mem_ready = 0; x_line = 5; y_line = 3; r = 8'h44;
        for (int i = 0; i < 4; i++) begin
            chk_acks($sformatf("bp_ack%0d", i), 3'b000);
            tick;
            chk($sformatf("bp_addr%0d", i),  32'(mem_addr),  32'd1);
            chk($sformatf("bp_valid%0d", i), 32'(mem_valid), 32'd1);
        end
        chk("bp_rgb_held", 32'(mem_r), 32'h11);
        mem_ready = 1;
        chk_acks("bp_release_ack", 3'b001);
        tick;
        chk("bp_new_addr",  32'(mem_addr),  32'd1925);
        chk("bp_new_valid", 32'(mem_valid), 32'd1);
        chk("bp_new_r",     32'(mem_r),     32'h44);
        req_line = 0;
        tick;
        chk("drain_valid", 32'(mem_valid), 32'd0);
        chk("drain_idle",  32'(idle),      32'd1);

        // Clip on x, then the last legal pixel.
        req_fill = 1; x_fill = 640; y_fill = 0;
        chk_acks("clipx_ack", 3'b010);
        tick;
        chk("clipx_pulse", 32'(clipped),   32'd1);
        chk("clipx_valid", 32'(mem_valid), 32'd0);
        x_fill = 639; y_fill = 479;
        chk_acks("corner_ack", 3'b010);
        tick;
        chk("corner_clip_end", 32'(clipped),   32'd0);
        chk("corner_valid",    32'(mem_valid), 32'd1);
        chk("corner_addr",     32'(mem_addr),  32'd307199);
        req_fill = 0;

        // Clip on y while the register drains.
        req_arc = 1; x_arc = 0; y_arc = 480;
        chk_acks("clipy_ack", 3'b100);
        tick;
        chk("clipy_pulse", 32'(clipped),   32'd1);
        chk("clipy_valid", 32'(mem_valid), 32'd0);
        req_arc = 0;

        // Fill grant, then arc alone gets the very next cycle.
        req_fill = 1; x_fill = 1; y_fill = 1;
        chk_acks("fill_ack", 3'b010);
        tick;
        chk("fill_addr", 32'(mem_addr), 32'd641);
        req_fill = 0;
        req_arc = 1; x_arc = 7; y_arc = 0;
        chk_acks("arc_only_ack", 3'b100);
        tick;
        chk("arc_only_addr",  32'(mem_addr),  32'd7);
        chk("arc_only_valid", 32'(mem_valid), 32'd1);

        // Reset mid-operation with all requests pending.
        req_line = 1; x_line = 4; y_line = 0;
        req_fill = 1; req_arc = 1; mem_ready = 0;
        rst = 1;
        tick;
        rst = 0;
        #1;
        chk("rst2_valid", 32'(mem_valid), 32'd0);
        mem_ready = 1;
        chk_acks("rst2_first_ack", 3'b001);
        tick;
        chk("rst2_addr", 32'(mem_addr), 32'd4);
        req_line = 0; req_fill = 0; req_arc = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
